// File: rtl/uart_frame_tx_if.sv
// ---------------------------------------------------------------------------
// uart_frame_tx_if
//   Bundles the coprocessor-facing signals of the frame transmitter.
//   master : frame producer (drives frame_in / frame_valid, observes status)
//   slave  : uart_frame_tx (accepts the frame, drives tx and status)
// Signals:
//   frame_in    FRAME_BYTES*DBITS  frame word, byte 0 in bits [DBITS-1:0]
//   frame_valid 1                  one-cycle request pulse
//   frame_ready 1                  transmitter idle, can accept a frame
//   tx          1                  serial line, idles high
//   byte_idx    8                  character currently on the line
//   frame_done  1                  one-cycle pulse after the last stop bit
//   overrun     1                  sticky: request arrived while busy
// ---------------------------------------------------------------------------
interface uart_frame_tx_if #(
   parameter int DBITS       = 8,
   parameter int FRAME_BYTES = 16
) ();
   logic [FRAME_BYTES*DBITS-1:0] frame_in;
   logic                         frame_valid;
   logic                         frame_ready;
   logic                         tx;
   logic [7:0]                   byte_idx;
   logic                         frame_done;
   logic                         overrun;

   modport master (
      output frame_in, frame_valid,
      input  frame_ready, tx, byte_idx, frame_done, overrun
   );

   modport slave (
      input  frame_in, frame_valid,
      output frame_ready, tx, byte_idx, frame_done, overrun
   );
endinterface

// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
//   Frame-level UART transmitter. Latches one FRAME_BYTES*DBITS-bit word on a
//   frame_valid pulse and sends it as FRAME_BYTES back-to-back 8N1 characters,
//   byte 0 first, each character LSB first, with no gap between characters.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (aborts a frame, tx returns high)
//   bus    uart_frame_tx_if.slave: frame_in, frame_valid, frame_ready, tx,
//          byte_idx, frame_done, overrun
// ---------------------------------------------------------------------------
module uart_frame_tx #(
   parameter int CLK_FREQ    = 103_340_000,
   parameter int BAUD        = 115_200,
   parameter int DBITS       = 8,
   parameter int FRAME_BYTES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_frame_tx_if.slave   bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W        = (DBITS > 1) ? $clog2(DBITS) : 1;
   localparam int FRAME_W      = FRAME_BYTES * DBITS;

   generate
      if (CLKS_PER_BIT < 2) begin : g_cpb_check
         $error("uart_frame_tx: CLK_FREQ/BAUD must be at least 2");
      end
      if (FRAME_BYTES > 256 || FRAME_BYTES < 1) begin : g_frame_check
         $error("uart_frame_tx: FRAME_BYTES must be in 1..256");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state_reg, state_next;
   logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
   logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
   logic [7:0]           byte_idx_reg, byte_idx_next;
   // The latched frame doubles as the shift register: every data bit shifts it
   // right by one, so after DBITS shifts the next character sits at the LSBs.
   logic [FRAME_W-1:0]   frame_reg, frame_next;
   logic                 frame_done_reg, frame_done_next;
   logic                 overrun_reg, overrun_next;
   logic                 bit_end;

   assign bit_end = (baud_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         baud_cnt_reg   <= '0;
         bit_cnt_reg    <= '0;
         byte_idx_reg   <= '0;
         frame_reg      <= '0;
         frame_done_reg <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         baud_cnt_reg   <= baud_cnt_next;
         bit_cnt_reg    <= bit_cnt_next;
         byte_idx_reg   <= byte_idx_next;
         frame_reg      <= frame_next;
         frame_done_reg <= frame_done_next;
         overrun_reg    <= overrun_next;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_next      = state_reg;
      baud_cnt_next   = baud_cnt_reg;
      bit_cnt_next    = bit_cnt_reg;
      byte_idx_next   = byte_idx_reg;
      frame_next      = frame_reg;
      frame_done_next = 1'b0;
      overrun_next    = overrun_reg | (bus.frame_valid && (state_reg != IDLE));

      case (state_reg)
         IDLE: begin
            if (bus.frame_valid) begin
               frame_next    = bus.frame_in;
               state_next    = START;
               baud_cnt_next = '0;
               bit_cnt_next  = '0;
               byte_idx_next = '0;
            end
         end

         START: begin
            if (bit_end) begin
               baud_cnt_next = '0;
               bit_cnt_next  = '0;
               state_next    = DATA;
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end

         DATA: begin
            if (bit_end) begin
               baud_cnt_next = '0;
               frame_next    = frame_reg >> 1;
               if (bit_cnt_reg == BIT_W'(DBITS - 1)) begin
                  state_next = STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + BIT_W'(1);
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end

         STOP: begin
            if (bit_end) begin
               baud_cnt_next = '0;
               if (byte_idx_reg == 8'(FRAME_BYTES - 1)) begin
                  state_next      = IDLE;
                  byte_idx_next   = '0;
                  frame_done_next = 1'b1;
               end else begin
                  // Next character starts immediately: no idle gap on the line.
                  state_next    = START;
                  byte_idx_next = byte_idx_reg + 8'd1;
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_W'(1);
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // Line level is a pure decode of the state, so an asynchronous reset of
   // state_reg returns tx high at once without emitting a partial stop bit.
   always_comb begin
      bus.tx = 1'b1;
      case (state_reg)
         START:   bus.tx = 1'b0;
         DATA:    bus.tx = frame_reg[0];
         default: bus.tx = 1'b1;
      endcase
   end

   assign bus.frame_ready = (state_reg == IDLE);
   assign bus.byte_idx    = byte_idx_reg;
   assign bus.frame_done  = frame_done_reg;
   assign bus.overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_tx
//   Self-checking bench for uart_frame_tx at CLK_FREQ=16, BAUD=1 (16 clocks
//   per bit). A table of frames is sent and the tx line decoded bit by bit;
//   reset values and an asynchronous mid-frame reset are hand-written.
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;

   localparam int CPB    = 16;
   localparam int NBYTES = 16;
   localparam int CHAR_C = 10 * CPB;
   localparam int FRAME_C = NBYTES * CHAR_C;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   uart_frame_tx_if #(.DBITS(8), .FRAME_BYTES(NBYTES)) bus ();

   uart_frame_tx #(
      .CLK_FREQ    (16),
      .BAUD        (1),
      .DBITS       (8),
      .FRAME_BYTES (NBYTES)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] frame;
      logic [127:0] exp;          // expected characters, char k in [8k+7:8k]
      bit           ovr_inject;   // pulse frame_valid (all 0xFF) 100 cycles in
      bit           b2b;          // next frame requested on the frame_done cycle
      logic         exp_overrun;  // overrun expected at frame_done
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Call on a negedge; the frame is accepted on the following posedge and
   // the task returns on the negedge right after acceptance (cycle 0).
   task automatic accept(input logic [127:0] f);
      bus.frame_in    = f;
      bus.frame_valid = 1'b1;
      @(negedge clk);
      bus.frame_valid = 1'b0;
      bus.frame_in    = '0;
   endtask

   // Starts at cycle 0 after acceptance, decodes all characters, and returns
   // on the cycle that must carry frame_done.
   task automatic check_frame(input string name, input logic [127:0] exp,
                              input bit ovr_inject, input logic exp_overrun);
      int   c;
      int   done_seen;
      logic [7:0] e;
      c = 0;
      done_seen = 0;
      chk($sformatf("%s ready_low", name), 32'(bus.frame_ready), 32'd0);
      for (int j = 0; j < NBYTES; j++) begin
         logic [9:0] bits;
         logic       stable;
         logic       first;
         logic [7:0] idx;
         stable = 1'b1;
         bits   = '0;
         idx    = '0;
         first  = 1'b0;
         for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < CPB; s++) begin
               if (c != 0) @(negedge clk);
               if (ovr_inject && c == 100) begin
                  bus.frame_in    = {128{1'b1}};
                  bus.frame_valid = 1'b1;
               end else if (ovr_inject && c == 101) begin
                  bus.frame_valid = 1'b0;
               end
               if (s == 0) first = bus.tx;
               else if (bus.tx !== first) stable = 1'b0;
               if (s == CPB / 2) begin
                  bits[b] = bus.tx;
                  if (b == 0) idx = bus.byte_idx;
               end
               if (bus.frame_done) done_seen++;
               c++;
            end
         end
         e = exp[j*8 +: 8];
         chk($sformatf("%s char%0d {stable,stop,data,start}", name, j),
             32'({stable, bits}), 32'({1'b1, 1'b1, e, 1'b0}));
         chk($sformatf("%s byte_idx%0d", name, j), 32'(idx), 32'(j));
      end
      chk($sformatf("%s no_early_done", name), 32'(done_seen), 32'd0);
      @(negedge clk);
      // c == FRAME_C here: the cycle after the final stop cycle
      chk($sformatf("%s frame_done", name), 32'(bus.frame_done), 32'd1);
      chk($sformatf("%s ready_at_done", name), 32'(bus.frame_ready), 32'd1);
      chk($sformatf("%s byte_idx_at_done", name), 32'(bus.byte_idx), 32'd0);
      chk($sformatf("%s overrun", name), 32'(bus.overrun), 32'(exp_overrun));
      $display("[TB] frame %s sent %0d cycles, decoded and checked", name, c);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.frame_in    = '0;
      bus.frame_valid = 1'b0;

      vecs[0] = '{"seq",   128'h0F0E0D0C0B0A09080706050403020100,
                           128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"a5",    {16{8'hA5}}, {16{8'hA5}},                1'b0, 1'b0, 1'b0};
      vecs[2] = '{"ovr",   {16{8'h3C}}, {16{8'h3C}},                1'b1, 1'b0, 1'b1};
      vecs[3] = '{"b2b_a", 128'h00112233445566778899AABBCCDDEEFF,
                           128'h00112233445566778899AABBCCDDEEFF,   1'b0, 1'b1, 1'b1};
      vecs[4] = '{"b2b_b", {16{8'h5A}}, {16{8'h5A}},                1'b0, 1'b0, 1'b1};

      // Reset values, while held and after release
      repeat (3) @(negedge clk);
      chk("rst tx", 32'(bus.tx), 32'd1);
      chk("rst ready", 32'(bus.frame_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst byte_idx", 32'(bus.byte_idx), 32'd0);
      chk("rst frame_done", 32'(bus.frame_done), 32'd0);
      chk("rst overrun", 32'(bus.overrun), 32'd0);
      chk("idle tx", 32'(bus.tx), 32'd1);

      // Table-driven frames
      for (int i = 0; i < 5; i++) begin
         if (i == 0 || !vecs[i-1].b2b) repeat (2) @(negedge clk);
         accept(vecs[i].frame);
         check_frame(vecs[i].name, vecs[i].exp, vecs[i].ovr_inject, vecs[i].exp_overrun);
         if (!vecs[i].b2b) begin
            @(negedge clk);
            chk($sformatf("%s done_one_cycle", vecs[i].name), 32'(bus.frame_done), 32'd0);
         end
      end

      // Mid-frame reset: byte 3 (0x03), data bit 4 (a 0 on the line)
      repeat (2) @(negedge clk);
      accept(vecs[0].frame);
      for (int c = 1; c <= 3 * CHAR_C + 5 * CPB + CPB / 2; c++) @(negedge clk);
      chk("midrst pre tx", 32'(bus.tx), 32'd0);
      chk("midrst pre byte_idx", 32'(bus.byte_idx), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst tx async", 32'(bus.tx), 32'd1);
      chk("midrst ready", 32'(bus.frame_ready), 32'd1);
      chk("midrst byte_idx", 32'(bus.byte_idx), 32'd0);
      chk("midrst overrun_cleared", 32'(bus.overrun), 32'd0);
      begin
         int done_cnt;
         done_cnt = 0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.frame_done || bus.tx !== 1'b1) done_cnt++;
         end
         rst_n = 1'b1;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.frame_done || bus.tx !== 1'b1) done_cnt++;
         end
         chk("midrst quiet_after", 32'(done_cnt), 32'd0);
      end
      accept(vecs[1].frame);
      check_frame("after_rst", vecs[1].exp, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
